// File: rtl/inst_fetch_unit.sv
// Fetch stage plus IF/ID register: owns the PC, drives the instruction memory
// address and hands {pc, instr, valid} to decode. Handles stalls, redirects, halt and faults.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          NUM_INST   = 128,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Extra headroom bits so 4*NUM_INST cannot wrap for any legal depth.
  localparam logic [33:0] PC_LIMIT = 34'(NUM_INST) << 2;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  ifid_t       ifid_q, ifid_n;
  ifid_t       bubble;
  logic        pc_bad, tgt_bad;
  logic [31:0] pc_inc;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a} >= PC_LIMIT);
  endfunction

  assign pc_bad  = addr_bad(pc_q);
  assign tgt_bad = addr_bad(redirect_target);
  assign pc_inc  = pc_q + 32'd4;

  // A bubble keeps the last PC so decode never sees a spurious address change.
  always_comb begin
    bubble       = ifid_q;
    bubble.instr = '0;
    bubble.valid = 1'b0;
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ifid_n  = ifid_q;
    unique case (state_q)
      S_IDLE: begin
        ifid_n = bubble;
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          ifid_n  = bubble;
          if (tgt_bad) state_n = S_FAULT;
        end else if (flush) begin
          ifid_n = bubble;
          if (!stall) pc_n = pc_inc;
        end else if (stall) begin
          pc_n   = pc_q;
        end else if (pc_bad) begin
          // Faulting address is never captured; pc stays on it for debug.
          ifid_n  = bubble;
          state_n = S_FAULT;
        end else begin
          ifid_n.pc    = pc_q;
          ifid_n.instr = imem_rdata;
          ifid_n.valid = 1'b1;
          pc_n         = pc_inc;
          if (imem_rdata == HALT_INSTR) state_n = S_HALT;
        end
      end
      S_HALT: begin
        ifid_n = bubble;
        if (redirect_valid) begin
          pc_n    = redirect_target;
          state_n = tgt_bad ? S_FAULT : S_RUN;
        end
      end
      S_FAULT: begin
        ifid_n = bubble;
      end
      default: begin
        state_n = S_IDLE;
        ifid_n  = bubble;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ifid_q  <= ifid_n;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_valid  = ifid_q.valid;
  assign halted      = (state_q == S_HALT);
  assign fetch_fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; memory model returns word = address
// unless the halt word is armed at 0x20.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid, halted, fetch_fault;
  logic        halt_en;
  int          n_chk = 0;
  int          n_fail = 0;

  inst_fetch_unit #(.RESET_PC(32'h0), .NUM_INST(128), .HALT_INSTR(32'h0000_0073)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  always_comb imem_rdata = (halt_en && imem_addr == 32'h20) ? 32'h0000_0073 : imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0; halt_en = 0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_fault} !== {32'h0, 32'h0, 32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: addr=%h pc=%h instr=%h v=%b h=%b f=%b", imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_fault);
    end
    tick(); tick();
    n_chk++;
    if ({imem_addr, ifid_valid} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_hold: addr=%h v=%b expected 0/0", imem_addr, ifid_valid);
    end
  endtask

  task automatic test_seq();
    do_reset();
    go();
    n_chk++;
    if ({imem_addr, ifid_valid} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL fill: addr=%h v=%b expected 0/0", imem_addr, ifid_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ({ifid_pc, ifid_instr, ifid_valid, imem_addr} !== {32'(4*i), 32'(4*i), 1'b1, 32'(4*i+4)}) begin
        n_fail++;
        $display("FAIL seq[%0d]: pc=%h instr=%h v=%b addr=%h expected pc=instr=%h", i, ifid_pc, ifid_instr, ifid_valid, imem_addr, 32'(4*i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    go();
    repeat (4) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({imem_addr, ifid_pc, ifid_instr, ifid_valid} !== {32'h10, 32'hC, 32'hC, 1'b1}) begin
        n_fail++;
        $display("FAIL stall[%0d]: addr=%h pc=%h instr=%h v=%b expected 10/C/C/1", i, imem_addr, ifid_pc, ifid_instr, ifid_valid);
      end
    end
    stall = 1'b0;
    tick();
    n_chk++;
    if ({imem_addr, ifid_pc, ifid_valid} !== {32'h14, 32'h10, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_resume: addr=%h pc=%h v=%b expected 14/10/1", imem_addr, ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    go();
    repeat (2) tick();
    flush = 1'b1;
    tick();
    n_chk++;
    if ({imem_addr, ifid_instr, ifid_valid} !== {32'hC, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush: addr=%h instr=%h v=%b expected C/0/0", imem_addr, ifid_instr, ifid_valid);
    end
    stall = 1'b1;
    tick();
    n_chk++;
    if ({imem_addr, ifid_valid} !== {32'hC, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_stall: addr=%h v=%b expected C/0", imem_addr, ifid_valid);
    end
    flush = 1'b0; stall = 1'b0;
    tick();
    n_chk++;
    if ({ifid_pc, ifid_valid, imem_addr} !== {32'hC, 1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL flush_resume: pc=%h v=%b addr=%h expected C/1/10", ifid_pc, ifid_valid, imem_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    go();
    repeat (2) tick();
    stall = 1'b1; flush = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    n_chk++;
    if ({imem_addr, ifid_valid, ifid_instr} !== {32'h40, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL redirect: addr=%h v=%b instr=%h expected 40/0/0", imem_addr, ifid_valid, ifid_instr);
    end
    tick();
    n_chk++;
    if ({ifid_pc, ifid_instr, ifid_valid} !== {32'h40, 32'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL redirect_fetch: pc=%h instr=%h v=%b expected 40/40/1", ifid_pc, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1'b1;
    go();
    repeat (9) tick();
    n_chk++;
    if ({ifid_pc, ifid_instr, ifid_valid, halted, imem_addr} !== {32'h20, 32'h73, 1'b1, 1'b1, 32'h24}) begin
      n_fail++;
      $display("FAIL halt_capture: pc=%h instr=%h v=%b h=%b addr=%h expected 20/73/1/1/24", ifid_pc, ifid_instr, ifid_valid, halted, imem_addr);
    end
    stall = 1'b1; flush = 1'b1; start = 1'b1;
    tick(); tick();
    stall = 1'b0; flush = 1'b0; start = 1'b0;
    n_chk++;
    if ({ifid_instr, ifid_valid, halted, imem_addr} !== {32'h0, 1'b0, 1'b1, 32'h24}) begin
      n_fail++;
      $display("FAIL halt_hold: instr=%h v=%b h=%b addr=%h expected 0/0/1/24", ifid_instr, ifid_valid, halted, imem_addr);
    end
    halt_en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h08;
    tick();
    redirect_valid = 1'b0;
    n_chk++;
    if ({halted, imem_addr, ifid_valid} !== {1'b0, 32'h08, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_redirect: h=%b addr=%h v=%b expected 0/08/0", halted, imem_addr, ifid_valid);
    end
    tick();
    n_chk++;
    if ({ifid_pc, ifid_valid, imem_addr} !== {32'h08, 1'b1, 32'h0C}) begin
      n_fail++;
      $display("FAIL halt_resume: pc=%h v=%b addr=%h expected 08/1/0C", ifid_pc, ifid_valid, imem_addr);
    end
  endtask

  task automatic test_fault();
    do_reset();
    go();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    redirect_valid = 1'b0;
    n_chk++;
    if ({fetch_fault, ifid_valid, imem_addr} !== {1'b1, 1'b0, 32'h42}) begin
      n_fail++;
      $display("FAIL fault_misalign: f=%b v=%b addr=%h expected 1/0/42", fetch_fault, ifid_valid, imem_addr);
    end
    redirect_valid = 1'b1; redirect_target = 32'h0; start = 1'b1;
    tick(); tick();
    redirect_valid = 1'b0; start = 1'b0;
    n_chk++;
    if ({fetch_fault, ifid_valid, imem_addr} !== {1'b1, 1'b0, 32'h42}) begin
      n_fail++;
      $display("FAIL fault_sticky: f=%b v=%b addr=%h expected 1/0/42", fetch_fault, ifid_valid, imem_addr);
    end
    do_reset();
    n_chk++;
    if ({fetch_fault, imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL fault_clear: f=%b addr=%h expected 0/0", fetch_fault, imem_addr);
    end
    go();
    redirect_valid = 1'b1; redirect_target = 32'h1F8;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    n_chk++;
    if ({ifid_pc, ifid_valid, imem_addr, fetch_fault} !== {32'h1FC, 1'b1, 32'h200, 1'b0}) begin
      n_fail++;
      $display("FAIL range_last: pc=%h v=%b addr=%h f=%b expected 1FC/1/200/0", ifid_pc, ifid_valid, imem_addr, fetch_fault);
    end
    tick();
    n_chk++;
    if ({fetch_fault, ifid_valid, imem_addr} !== {1'b1, 1'b0, 32'h200}) begin
      n_fail++;
      $display("FAIL range_fault: f=%b v=%b addr=%h expected 1/0/200", fetch_fault, ifid_valid, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go();
    repeat (3) tick();
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_fault} !== {32'h0, 32'h0, 32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h pc=%h instr=%h v=%b h=%b f=%b", imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, fetch_fault);
    end
    rstn = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({imem_addr, ifid_valid} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_idle: addr=%h v=%b expected 0/0", imem_addr, ifid_valid);
    end
    go();
    tick();
    n_chk++;
    if ({ifid_pc, ifid_valid, imem_addr} !== {32'h0, 1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL post_reset_run: pc=%h v=%b addr=%h expected 0/1/4", ifid_pc, ifid_valid, imem_addr);
    end
  endtask

  initial begin
    rstn = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_seq();
    test_stall();
    test_flush();
    test_redirect();
    test_halt();
    test_fault();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
